care_cmd_parser: RTL and testbench
==================================

Name: care_cmd_parser

Overview:
Host-side care-command front end. Consumes the byte stream from the UART receiver and parses framed ASCII commands of the form "!<cmd><digit><CR|LF>". It emits one validated care action per frame to the stats block: which stat to act on, plus an amount. It also enforces an inter-byte timeout and a global post-action cooldown counted in 1 Hz ticks.

Parameters:
TIMEOUT_CYCLES, 24'd10_000_000, clk cycles allowed between bytes inside a frame before abort.
COOLDOWN_S, 4'd4, seconds after an accepted action during which new frames are rejected; 0 disables cooldown.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
second  in  1  one-cycle 1 Hz tick
act_valid  out  1  one-cycle pulse; action fields valid
act_code  out  3  0 feed/hunger, 1 play/happiness, 2 medicine/health, 3 wash/hygiene, 4 sleep/energy, 5 talk/social
act_amount  out  4  amount 1..9
err_valid  out  1  one-cycle pulse on rejected or aborted frame
err_code  out  2  1 syntax, 2 timeout, 3 cooldown
busy  out  1  high while FSM not in IDLE
cooldown  out  4  remaining cooldown seconds

Behaviour:
- Reset (async): FSM=IDLE; all outputs 0; timeout counter 0; cooldown 0; latched cmd/amount 0.
- FSM states: IDLE, CMD, AMT, TERM.
  - IDLE: byte 0x21 '!' -> CMD. Any other byte is ignored silently.
  - CMD: letters F/P/M/W/S/T (upper or lower case) latch the code -> AMT. Byte '!' -> stays CMD (restart). Other byte -> syntax error, IDLE.
  - AMT: '1'..'9' (0x31..0x39) latch value-0x30 -> TERM. '!' -> CMD. '0' or other byte -> syntax error, IDLE.
  - TERM: 0x0D or 0x0A -> frame complete, IDLE. '!' -> CMD. Other byte -> syntax error, IDLE.
- Frame complete:
  - If cooldown==0: act_valid=1 next cycle, with act_code/act_amount. Cooldown loads COOLDOWN_S in the same cycle.
  - If cooldown!=0: err_valid=1, err_code=3, no action.
  - Latency: terminator byte at cycle N -> pulse at N+1.
- act_code/act_amount hold their last value between pulses. err_code likewise holds.
- Restart via '!' mid-frame: silent, no error pulse.
- Timeout:
  - Counter clears on every rx_valid and in IDLE; increments each cycle in CMD/AMT/TERM.
  - Reaching TIMEOUT_CYCLES-1 without a byte -> err_valid, err_code=2, IDLE. The counter saturates (no wrap).
  - If rx_valid and timeout expiry fall in the same cycle, the byte wins: it is processed and the counter clears.
- Cooldown:
  - Decrements by 1 on second while nonzero; never wraps below 0.
  - If a load and second coincide, the load wins.
- act_valid and err_valid are mutually exclusive and never both high.
- Bytes are processed only when rx_valid=1; rx_data is don't-care otherwise.
- Reset asserted mid-frame returns to IDLE immediately, with no pulse.
- Output pulses are registered; no combinational path from rx_data to outputs.

Test Plan:
- Send "!F3\n" with cooldown 0 -> exactly one act_valid, one cycle after '\n'; act_code=0, act_amount=3; then cooldown=4, busy=0.
- Send "!p9\r", then "!S1\n" before 4 second ticks elapse -> first frame: act_code=1, act_amount=9; second frame: err_valid, err_code=3, no act_valid. After 4 ticks, send "!S1\n" -> act_code=4, act_amount=1.
- Send "!X", "!F0", "!T5A" as separate frames -> three err_valid pulses with err_code=1; FSM returns to IDLE each time.
- Send "!M" then idle for TIMEOUT_CYCLES (use TIMEOUT_CYCLES=100 in the bench) -> err_code=2 at cycle 99 after the last byte; busy drops. In a separate run, deliver a byte exactly at the expiry cycle -> no timeout error.
- Send "!W!T7\n" -> single act_valid with act_code=5, act_amount=7; no error pulse. Leading garbage "abc" in IDLE -> no response.
- Assert reset during AMT, release, then send "!F2\n" -> no pulse during reset; after release, act_code=0, act_amount=2. Drive second continuously with cooldown=0 -> cooldown stays 0.

Source files
------------

// File: rtl/care_cmd_parser.sv
// Parses framed ASCII care commands "!<cmd><digit><CR|LF>" from the UART byte stream.
// Each frame yields one registered action or error pulse. Inter-byte timeout and post-action cooldown are enforced.
module care_cmd_parser #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
  parameter logic [3:0]  COOLDOWN_S     = 4'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       second,
  output logic       act_valid,
  output logic [2:0] act_code,
  output logic [3:0] act_amount,
  output logic       err_valid,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [3:0] cooldown
);

  typedef enum logic [1:0] {IDLE, CMD, AMT, TERM} state_t;

  localparam logic [1:0] ERR_SYNTAX   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_COOLDOWN = 2'd3;

  state_t      state_q, state_d;
  logic [23:0] tmo_q, tmo_d;
  logic [3:0]  cd_q, cd_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [3:0]  amt_q, amt_d;
  logic        act_valid_q, act_valid_d;
  logic [2:0]  act_code_q, act_code_d;
  logic [3:0]  act_amount_q, act_amount_d;
  logic        err_valid_q, err_valid_d;
  logic [1:0]  err_code_q, err_code_d;

  logic [7:0] up;
  logic       cmd_hit;
  logic [2:0] cmd_dec;
  logic       is_bang, is_digit, is_term;

  // Clearing bit 5 folds lower-case letters onto upper case; only 'x' and 'X' map to 'X'.
  assign up       = rx_data & 8'hDF;
  assign is_bang  = (rx_data == 8'h21);
  assign is_digit = (rx_data >= 8'h31) && (rx_data <= 8'h39);
  assign is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);

  always_comb begin
    cmd_hit = 1'b1;
    cmd_dec = 3'd0;
    case (up)
      8'h46:   cmd_dec = 3'd0; // F feed
      8'h50:   cmd_dec = 3'd1; // P play
      8'h4D:   cmd_dec = 3'd2; // M medicine
      8'h57:   cmd_dec = 3'd3; // W wash
      8'h53:   cmd_dec = 3'd4; // S sleep
      8'h54:   cmd_dec = 3'd5; // T talk
      default: cmd_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    amt_d        = amt_q;
    act_valid_d  = 1'b0;
    act_code_d   = act_code_q;
    act_amount_d = act_amount_q;
    err_valid_d  = 1'b0;
    err_code_d   = err_code_q;
    cd_d         = (second && cd_q != 4'd0) ? cd_q - 4'd1 : cd_q;

    if (state_q == IDLE || rx_valid)
      tmo_d = 24'd0;
    else if (tmo_q != TIMEOUT_CYCLES - 24'd1)
      tmo_d = tmo_q + 24'd1;
    else
      tmo_d = tmo_q;

    if (rx_valid) begin
      case (state_q)
        IDLE: if (is_bang) state_d = CMD;
        CMD: begin
          if (is_bang) state_d = CMD;
          else if (cmd_hit) begin
            cmd_d   = cmd_dec;
            state_d = AMT;
          end else begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_SYNTAX;
            state_d     = IDLE;
          end
        end
        AMT: begin
          if (is_bang) state_d = CMD;
          else if (is_digit) begin
            amt_d   = rx_data[3:0];
            state_d = TERM;
          end else begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_SYNTAX;
            state_d     = IDLE;
          end
        end
        TERM: begin
          if (is_bang) state_d = CMD;
          else if (is_term) begin
            state_d = IDLE;
            if (cd_q == 4'd0) begin
              act_valid_d  = 1'b1;
              act_code_d   = cmd_q;
              act_amount_d = amt_q;
              cd_d         = COOLDOWN_S;
            end else begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_COOLDOWN;
            end
          end else begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_SYNTAX;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TIMEOUT_CYCLES - 24'd2) begin
      // The counter reaches TIMEOUT_CYCLES-1 on this edge; a byte arriving now would have won.
      err_valid_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tmo_q        <= 24'd0;
      cd_q         <= 4'd0;
      cmd_q        <= 3'd0;
      amt_q        <= 4'd0;
      act_valid_q  <= 1'b0;
      act_code_q   <= 3'd0;
      act_amount_q <= 4'd0;
      err_valid_q  <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      cd_q         <= cd_d;
      cmd_q        <= cmd_d;
      amt_q        <= amt_d;
      act_valid_q  <= act_valid_d;
      act_code_q   <= act_code_d;
      act_amount_q <= act_amount_d;
      err_valid_q  <= err_valid_d;
      err_code_q   <= err_code_d;
    end
  end

  assign act_valid  = act_valid_q;
  assign act_code   = act_code_q;
  assign act_amount = act_amount_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q != IDLE);
  assign cooldown   = cd_q;

endmodule

// File: tb/tb_care_cmd_parser.sv
// Bench for care_cmd_parser: directed scenarios followed by random byte traffic.
// Outputs are compared every cycle against a string-level frame parser model.
module tb_care_cmd_parser;

  localparam int TO   = 100;
  localparam int COOL = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       second = 1'b0;
  logic       act_valid, err_valid, busy;
  logic [2:0] act_code;
  logic [3:0] act_amount, cooldown;
  logic [1:0] err_code;

  care_cmd_parser #(.TIMEOUT_CYCLES(24'(TO)), .COOLDOWN_S(4'(COOL))) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .second(second),
    .act_valid(act_valid), .act_code(act_code), .act_amount(act_amount),
    .err_valid(err_valid), .err_code(err_code), .busy(busy), .cooldown(cooldown)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: bytes collected since the last '!' and judged by position.
  bit         m_in_frame;
  logic [7:0] m_frm[$];
  int         m_idle;
  int         m_cd;
  bit         m_av, m_ev;
  int         m_code, m_amt, m_ec;

  bit any_act, any_err;

  function automatic int letter(input logic [7:0] b);
    string s = "FPMWST";
    for (int i = 0; i < 6; i++)
      if (b == s[i] || b == (s[i] | 8'h20)) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_in_frame = 0; m_frm.delete(); m_idle = 0; m_cd = 0;
    m_av = 0; m_ev = 0; m_code = 0; m_amt = 0; m_ec = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] b, input bit sec);
    bit accept = 0;
    bit ok;
    m_av = 0; m_ev = 0;
    if (v) begin
      m_idle = 0;
      if (b == 8'h21) begin
        m_in_frame = 1; m_frm.delete();
      end else if (m_in_frame) begin
        m_frm.push_back(b);
        ok = 0;
        case (m_frm.size())
          1: ok = letter(b) >= 0;
          2: ok = (b >= 8'h31 && b <= 8'h39);
          default: ok = (b == 8'h0D || b == 8'h0A);
        endcase
        if (!ok) begin
          m_in_frame = 0; m_ev = 1; m_ec = 1;
        end else if (m_frm.size() == 3) begin
          m_in_frame = 0;
          if (m_cd == 0) begin
            accept = 1; m_av = 1;
            m_code = letter(m_frm[0]); m_amt = int'(m_frm[1]) - 48;
          end else begin
            m_ev = 1; m_ec = 3;
          end
        end
      end
    end else if (m_in_frame) begin
      m_idle++;
      if (m_idle == TO - 1) begin
        m_in_frame = 0; m_ev = 1; m_ec = 2;
      end
    end
    if (accept) m_cd = COOL;
    else if (sec && m_cd > 0) m_cd--;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] b, input bit sec);
    logic [15:0] obs, exp;
    rx_valid = v; rx_data = v ? b : 8'($urandom); second = sec;
    model_step(v, b, sec);
    @(posedge clk);
    #1;
    obs = {act_valid, act_code, act_amount, err_valid, err_code, busy, cooldown};
    exp = {m_av, 3'(m_code), 4'(m_amt), m_ev, 2'(m_ec), m_in_frame, 4'(m_cd)};
    chk("cycle", 32'(obs), 32'(exp));
    if (act_valid && err_valid) chk("exclusive", 32'd1, 32'd0);
    any_act |= act_valid;
    any_err |= err_valid;
  endtask

  task automatic send(input string s);
    any_act = 0; any_err = 0;
    for (int i = 0; i < s.len(); i++) cyc(1, s[i], 0);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 1);
  endtask

  initial begin
    int got;
    string pool;
    string lt;
    model_reset();
    #2;
    chk("reset_outs", 32'({act_valid, act_code, act_amount, err_valid, err_code, busy, cooldown}), 32'd0);
    repeat (2) @(posedge clk);
    #4 reset = 1'b0;

    // Garbage while idle
    send("abc");
    chk("garbage_quiet", 32'({any_act, any_err, busy}), 32'd0);

    // Basic accepted frame
    send("!F3\n");
    chk("f3_act", 32'({act_valid, act_code, act_amount}), 32'({1'b1, 3'd0, 4'd3}));
    chk("f3_cd_busy", 32'({cooldown, busy}), 32'({4'd4, 1'b0}));
    tick(4);
    chk("cd_expired", 32'(cooldown), 32'd0);

    // Cooldown rejection
    send("!p9\015");
    chk("p9_act", 32'({act_valid, act_code, act_amount}), 32'({1'b1, 3'd1, 4'd9}));
    send("!S1\n");
    chk("s1_cooldown", 32'({act_valid, err_valid, err_code}), 32'({1'b0, 1'b1, 2'd3}));
    chk("s1_no_act", 32'(any_act), 32'd0);
    tick(4);
    send("!S1\n");
    chk("s1_act", 32'({act_valid, act_code, act_amount}), 32'({1'b1, 3'd4, 4'd1}));
    tick(4);

    // Syntax errors
    send("!X");
    chk("syn_x", 32'({err_valid, err_code, busy}), 32'({1'b1, 2'd1, 1'b0}));
    send("!F0");
    chk("syn_f0", 32'({err_valid, err_code, busy}), 32'({1'b1, 2'd1, 1'b0}));
    send("!T5A");
    chk("syn_t5a", 32'({err_valid, err_code, busy}), 32'({1'b1, 2'd1, 1'b0}));
    chk("syn_no_act", 32'(any_act), 32'd0);

    // Timeout after 99 idle cycles
    send("!M");
    got = -1;
    for (int k = 1; k <= 150; k++) begin
      cyc(0, 8'h00, 0);
      if (err_valid) begin got = k; break; end
    end
    chk("tmo_latency", 32'(got), 32'd99);
    chk("tmo_code_busy", 32'({err_code, busy}), 32'({2'd2, 1'b0}));

    // Byte exactly at expiry wins
    send("!M");
    repeat (98) cyc(0, 8'h00, 0);
    any_err = 0;
    cyc(1, "5", 0);
    chk("tmo_edge_byte", 32'({err_valid, busy}), 32'({1'b0, 1'b1}));
    send("\n");
    chk("tmo_edge_act", 32'({act_valid, act_code, act_amount}), 32'({1'b1, 3'd2, 4'd5}));
    tick(4);

    // Restart mid-frame
    send("!W!T7\n");
    chk("restart_act", 32'({act_valid, act_code, act_amount}), 32'({1'b1, 3'd5, 4'd7}));
    chk("restart_no_err", 32'(any_err), 32'd0);
    tick(4);

    // Reset in AMT
    send("!F");
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", 32'({act_valid, err_valid, busy, cooldown}), 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_hold", 32'({act_valid, err_valid, busy}), 32'd0);
    model_reset();
    reset = 1'b0;
    send("!F2\n");
    chk("post_rst_act", 32'({act_valid, act_code, act_amount}), 32'({1'b1, 3'd0, 4'd2}));
    tick(4);
    repeat (10) cyc(0, 8'h00, 1);
    chk("cd_stays_zero", 32'(cooldown), 32'd0);

    // Random traffic: well-formed frames mixed with arbitrary bytes and gaps
    pool = "!!!FfPpMmWwSsTtXa0123456789\015\n\015\n";
    lt = "FPMWSTfpmwst";
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        cyc(1, 8'h21, $urandom_range(0, 7) == 0);
        cyc(1, lt[$urandom_range(0, 11)], $urandom_range(0, 7) == 0);
        cyc(1, 8'(8'h31 + $urandom_range(0, 8)), $urandom_range(0, 7) == 0);
        cyc(1, ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A, $urandom_range(0, 7) == 0);
      end else begin
        cyc(1, pool[$urandom_range(0, pool.len() - 1)], $urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 40) == 0)
        repeat ($urandom_range(95, 105)) cyc(0, 8'h00, $urandom_range(0, 7) == 0);
      else
        repeat ($urandom_range(0, 3)) cyc(0, 8'h00, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
